wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator.sv | 165 ++++++++++++++++
 tb/tb_wb_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//
// Purpose:
//   Converts single commands from a valid/ready command port into one
//   Wishbone classic bus cycle, then returns the result on a valid/ready
//   response port. Only one transaction is in flight at a time, and every
//   output comes straight from a register.
//
// Optional feature:
//   Define WB_INITIATOR_TIMEOUT_EN to add a bus-cycle timeout. When the
//   responder gives no ack/err for TIMEOUT_CYCLES cycles, the cycle is
//   abandoned and an error response is returned. Without the macro the
//   initiator waits in the bus phase indefinitely.
//
// Parameters:
//   ADDR_W          Wishbone word-address width
//   DATA_W          data width (byte-select width = DATA_W/8)
//   TIMEOUT_CYCLES  cycles to wait for ack/err (used only with the timeout)
//
// Ports:
//   sys_clk, sys_rst        clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_we/adr/dat/sel      command fields (we=1 for a write)
//   wb_cyc/stb/we/adr/
//   wb_dat_w/sel            Wishbone initiator outputs
//   wb_dat_r/ack/err        Wishbone responder inputs
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat, rsp_err        read data (0 for writes/errors), error flag
// ---------------------------------------------------------------------------
module wb_initiator #(
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_adr,
    input  logic [DATA_W-1:0]     cmd_dat,
    input  logic [DATA_W/8-1:0]   cmd_sel,
    // Wishbone initiator side
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_adr,
    output logic [DATA_W-1:0]     wb_dat_w,
    output logic [DATA_W/8-1:0]   wb_sel,
    input  logic [DATA_W-1:0]     wb_dat_r,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic                  rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic       w_tmo;
    logic       w_bus_done;
    logic       w_bus_fail;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counter sits at zero outside the bus phase, so it is always fresh on
    // entry. The terminal count flags the last permitted bus cycle.
    assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || (r_state != S_BUS)) begin
            r_tmo_cnt <= '0;
        end else if (!w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // ack/err are only meaningful while the bus cycle is active; err (or a
    // timeout) takes precedence over a simultaneous ack.
    assign w_bus_done = wb_ack || wb_err || w_tmo;
    assign w_bus_fail = wb_err || w_tmo;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_w  <= '0;
            wb_sel    <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Command fields are frozen here and held on the bus
                        // until the responder terminates the cycle.
                        r_state   <= S_BUS;
                        cmd_ready <= 1'b0;
                        wb_cyc    <= 1'b1;
                        wb_stb    <= 1'b1;
                        wb_we     <= cmd_we;
                        wb_adr    <= cmd_adr;
                        wb_dat_w  <= cmd_dat;
                        wb_sel    <= cmd_sel;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_BUS: begin
                    if (w_bus_done) begin
                        r_state   <= S_RESP;
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (w_bus_fail) begin
                            rsp_err <= 1'b1;
                            rsp_dat <= '0;
                        end else begin
                            rsp_err <= 1'b0;
                            rsp_dat <= wb_we ? '0 : wb_dat_r;
                        end
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        // cmd_ready rises together with the return to IDLE so
                        // a new command can be taken on the very next edge.
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b0;
                    wb_cyc    <= 1'b0;
                    wb_stb    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
//
// Directed bench for wb_initiator. Stimulus tasks push the expected response
// into a queue when a command is issued; an independent monitor pops and
// compares each time a response handshake occurs. Bus-side behaviour
// (stability, cycle counts, reset effects) is checked inline.
// Define WB_INITIATOR_TIMEOUT_EN to exercise the timeout (TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_wb_initiator;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_w;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_dat_r = 32'hCAFEF00D;
    logic          wb_ack = 1'b0;
    logic          wb_err = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;

    wb_initiator #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_sel   (wb_sel),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] dat, input logic err);
        rsp_t r;
        r.dat = dat;
        r.err = err;
        exp_q.push_back(r);
    endtask

    // Scoreboard monitor: a response is consumed on the edge following a
    // negedge where valid and ready are both high.
    always @(negedge sys_clk) begin
        if (!sys_rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'(1'b0));
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Waits (bounded) for cmd_ready, presents a command for one edge, then
    // scrambles the command inputs so later checks prove they were latched.
    task automatic issue(input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        int n = 0;
        @(negedge sys_clk);
        while (!cmd_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1'b1));
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = ~adr;
        cmd_dat   = ~dat;
        cmd_sel   = ~sel;
    endtask

    // Responder: checks the bus is held for waits+1 stb cycles, terminates
    // with the given ack/err, then checks cyc drops and a response appears.
    task automatic respond(input int waits, input logic ack, input logic err,
                           input logic [DW-1:0] rdat, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel);
        for (int i = 0; i <= waits; i++) begin
            @(negedge sys_clk);
            chk("bus_cyc", 64'(wb_cyc), 64'(1'b1));
            chk("bus_stb", 64'(wb_stb), 64'(1'b1));
            chk("bus_we",  64'(wb_we),  64'(we));
            chk("bus_adr", 64'(wb_adr), 64'(adr));
            chk("bus_dat_w", 64'(wb_dat_w), 64'(dat));
            chk("bus_sel", 64'(wb_sel), 64'(sel));
            chk("cmd_ready_in_bus", 64'(cmd_ready), 64'(1'b0));
            if (i == waits) begin
                wb_ack   = ack;
                wb_err   = err;
                wb_dat_r = rdat;
            end
        end
        @(posedge sys_clk);
        #1;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_r = 32'hCAFEF00D;
        @(negedge sys_clk);
        chk("cyc_drop", 64'(wb_cyc), 64'(1'b0));
        chk("stb_drop", 64'(wb_stb), 64'(1'b0));
        chk("rsp_valid_up", 64'(rsp_valid), 64'(1'b1));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        chk("rst_cyc", 64'(wb_cyc), 64'(1'b0));
        chk("rst_stb", 64'(wb_stb), 64'(1'b0));
        chk("rst_we", 64'(wb_we), 64'(1'b0));
        chk("rst_adr", 64'(wb_adr), 64'(0));
        chk("rst_dat_w", 64'(wb_dat_w), 64'(0));
        chk("rst_sel", 64'(wb_sel), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_rsp_dat", 64'(rsp_dat), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(1'b0));
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Read, ack after one wait cycle (cyc high exactly 2 cycles)
        push_exp(32'hDEADBEEF, 1'b0);
        issue(1'b0, 30'h10, 32'h0, 4'hF);
        respond(1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 30'h10, 32'h0, 4'hF);

        // Write, ack after three wait cycles; read data on bus must be ignored
        push_exp(32'h0, 1'b0);
        issue(1'b1, 30'h2A, 32'h12345678, 4'hF);
        respond(3, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 30'h2A, 32'h12345678, 4'hF);

        // Simultaneous ack and err: err wins
        push_exp(32'h0, 1'b1);
        issue(1'b0, 30'h3, 32'h0, 4'h1);
        respond(0, 1'b1, 1'b1, 32'h11111111, 1'b0, 30'h3, 32'h0, 4'h1);

        // Zero-wait read at top address; minimum latency
        push_exp(32'hA5A55A5A, 1'b0);
        issue(1'b0, 30'h3FFFFFFF, 32'h0, 4'h6);
        respond(0, 1'b1, 1'b0, 32'hA5A55A5A, 1'b0, 30'h3FFFFFFF, 32'h0, 4'h6);
        @(negedge sys_clk);
        chk("lat_cmd_ready_back", 64'(cmd_ready), 64'(1'b1));
        chk("lat_rsp_valid_low", 64'(rsp_valid), 64'(1'b0));

        // ack/err outside the bus phase are ignored
        @(posedge sys_clk);
        #1;
        wb_ack = 1'b1;
        wb_err = 1'b1;
        @(posedge sys_clk);
        #1;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        @(negedge sys_clk);
        chk("idle_ack_no_rsp", 64'(rsp_valid), 64'(1'b0));
        chk("idle_ack_no_cyc", 64'(wb_cyc), 64'(1'b0));

        // Backpressure: response held for 5+ cycles, new command refused
        rsp_ready = 1'b0;
        push_exp(32'h0BADF00D, 1'b0);
        push_exp(32'h0, 1'b0);
        issue(1'b0, 30'h44, 32'h0, 4'h3);
        respond(0, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 30'h44, 32'h0, 4'h3);
        for (int k = 0; k < 5; k++) begin
            @(posedge sys_clk);
            #1;
            cmd_valid = 1'b1;
            cmd_we    = 1'b1;
            cmd_adr   = 30'h55;
            cmd_dat   = 32'h87654321;
            cmd_sel   = 4'hC;
            @(negedge sys_clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1'b1));
            chk("bp_rsp_dat", 64'(rsp_dat), 64'(32'h0BADF00D));
            chk("bp_rsp_err", 64'(rsp_err), 64'(1'b0));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(1'b0));
            chk("bp_no_cyc", 64'(wb_cyc), 64'(1'b0));
        end
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("bp_cmd_ready_after", 64'(cmd_ready), 64'(1'b1));
        chk("bp_no_cyc_before_accept", 64'(wb_cyc), 64'(1'b0));
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        respond(0, 1'b1, 1'b0, 32'h77777777, 1'b1, 30'h55, 32'h87654321, 4'hC);

        // Reset mid-bus, with an ack on the same edge: reset wins
        issue(1'b0, 30'h66, 32'h0, 4'hF);
        @(negedge sys_clk);
        chk("rstmid_stb_before", 64'(wb_stb), 64'(1'b1));
        sys_rst = 1'b1;
        wb_ack  = 1'b1;
        @(posedge sys_clk);
        #1;
        wb_ack = 1'b0;
        @(negedge sys_clk);
        chk("rstmid_cyc", 64'(wb_cyc), 64'(1'b0));
        chk("rstmid_stb", 64'(wb_stb), 64'(1'b0));
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        chk("rstmid_adr", 64'(wb_adr), 64'(0));
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("rstmid_no_rsp_after", 64'(rsp_valid), 64'(1'b0));
        chk("rstmid_idle_ready", 64'(cmd_ready), 64'(1'b1));

`ifdef WB_INITIATOR_TIMEOUT_EN
        // Timeout: no responder reply, cyc drops after 8 bus cycles
        begin
            int hi = 0;
            push_exp(32'h0, 1'b1);
            issue(1'b0, 30'h77, 32'h0, 4'hF);
            for (int i = 0; i < 12; i++) begin
                @(negedge sys_clk);
                if (wb_cyc) hi++;
                if (i == 8) begin
                    chk("tmo_rsp_valid", 64'(rsp_valid), 64'(1'b1));
                    chk("tmo_rsp_err", 64'(rsp_err), 64'(1'b1));
                end
            end
            chk("tmo_cyc_cycles", 64'(hi), 64'(8));
        end
`else
        // No timeout: bus waits indefinitely, then completes normally
        begin
            int hi = 0;
            push_exp(32'h13579BDF, 1'b0);
            issue(1'b0, 30'h77, 32'h0, 4'hF);
            for (int i = 0; i < 300; i++) begin
                @(negedge sys_clk);
                if (wb_cyc) hi++;
            end
            chk("notmo_cyc_held", 64'(hi), 64'(300));
            chk("notmo_no_rsp", 64'(rsp_valid), 64'(1'b0));
            respond(0, 1'b1, 1'b0, 32'h13579BDF, 1'b0, 30'h77, 32'h0, 4'hF);
        end
`endif

        repeat (4) @(negedge sys_clk);
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
